// File: rtl/lcd_char_ctrl.sv
// HD44780-compatible character LCD controller (8-bit, write-only bus).
// Text lives in an internal ROWS*COLS buffer written through a byte port.
// After the power-on wait and the init commands, the buffer is streamed to
// the panel one row at a time. Each row starts with a DDRAM address command.
// Scanning is either continuous or on demand (buffer dirty / refresh_req).
module lcd_char_ctrl #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int COLS         = 16,
  parameter int ROWS         = 2,
  parameter int AUTO_REFRESH = 1,
  parameter int T_PWR_US     = 40_000,
  parameter int T_CMD_US     = 50,
  parameter int T_CLR_US     = 2_000,
  parameter int T_EN_NS      = 500,
  localparam int AW          = $clog2(ROWS * COLS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          refresh_req,
  output logic          lcd_rs,
  output logic          lcd_rw,
  output logic          lcd_en,
  output logic [7:0]    lcd_data,
  output logic          init_done,
  output logic          frame_done
);

  localparam int CELLS = ROWS * COLS;

  // Cycle counts are rounded up so that every delay is at least the
  // datasheet minimum at any clock frequency.
  localparam longint PWR_L = (longint'(T_PWR_US) * longint'(CLK_HZ) + longint'(999_999)) / longint'(1_000_000);
  localparam longint CMD_L = (longint'(T_CMD_US) * longint'(CLK_HZ) + longint'(999_999)) / longint'(1_000_000);
  localparam longint CLR_L = (longint'(T_CLR_US) * longint'(CLK_HZ) + longint'(999_999)) / longint'(1_000_000);
  localparam longint EN_L  = (longint'(T_EN_NS)  * longint'(CLK_HZ) + longint'(999_999_999)) / longint'(1_000_000_000);
  localparam int PWR_CYC = (PWR_L < 1) ? 1 : int'(PWR_L);
  localparam int CMD_CYC = (CMD_L < 1) ? 1 : int'(CMD_L);
  localparam int CLR_CYC = (CLR_L < 1) ? 1 : int'(CLR_L);
  localparam int EN_CYC  = (EN_L  < 1) ? 1 : int'(EN_L);

  typedef enum logic [2:0] {S_PWR, S_INIT, S_ROW, S_CHAR, S_END, S_IDLE} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_EN, PH_HOLD} phase_t;

  state_t        r_state, w_state_next;
  phase_t        r_phase, w_phase_next;
  logic [31:0]   r_cnt, w_cnt_next;
  logic [1:0]    r_init_idx, w_init_idx_next;
  logic [1:0]    r_row, w_row_next;
  logic [5:0]    r_col, w_col_next;
  logic          r_rs;
  logic [7:0]    r_data;
  logic          r_init_done;
  logic          r_dirty;
  logic          r_stale;
  logic          r_pend;
  logic [AW:0]   r_sent;
  logic [7:0]    r_buf [CELLS];

  logic          w_load;
  logic          w_load_char;
  logic          w_load_rs;
  logic [7:0]    w_load_data;
  logic          w_tx_done;
  logic          w_init_done_set;
  logic          w_end;
  logic          w_leave_idle;
  logic          w_in_tx;
  logic [31:0]   w_hold_last;
  logic          w_wr_ok;
  logic [AW:0]   w_frontier;
  logic          w_stale_wr;

  function automatic logic [7:0] f_init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  // Row r starts at 0x00, 0x40, COLS, 0x40+COLS (4-row panels interleave).
  function automatic logic [7:0] f_row_cmd(input logic [1:0] r);
    logic [7:0] base;
    base = (r[0] ? 8'h40 : 8'h00) + (r[1] ? 8'(COLS) : 8'h00);
    return 8'h80 | base;
  endfunction

  function automatic logic [AW-1:0] f_idx(input logic [1:0] r, input logic [5:0] c);
    return AW'(int'(r) * COLS + int'(c));
  endfunction

  assign w_in_tx     = (r_state == S_INIT) || (r_state == S_ROW) || (r_state == S_CHAR);
  // The clear command needs the long wait; everything else uses the short one.
  assign w_hold_last = (!r_rs && r_data == 8'h01) ? 32'(CLR_CYC - 1) : 32'(CMD_CYC - 1);
  assign w_wr_ok     = wr_en && ({1'b0, wr_addr} < (AW + 1)'(CELLS));
  // Cells below the frontier have already been sampled this frame, including
  // one sampled on this very edge (so a same-cycle write sends the old value).
  assign w_frontier  = r_sent + (AW + 1)'(w_load_char);
  assign w_stale_wr  = w_wr_ok && ({1'b0, wr_addr} < w_frontier);

  // Next-state logic: transaction phase sequencing plus frame walk.
  always_comb begin
    w_state_next    = r_state;
    w_phase_next    = r_phase;
    w_cnt_next      = r_cnt + 32'd1;
    w_init_idx_next = r_init_idx;
    w_row_next      = r_row;
    w_col_next      = r_col;
    w_load          = 1'b0;
    w_load_char     = 1'b0;
    w_load_rs       = 1'b0;
    w_load_data     = 8'h00;
    w_tx_done       = 1'b0;
    w_init_done_set = 1'b0;
    w_end           = 1'b0;
    w_leave_idle    = 1'b0;

    if (w_in_tx) begin
      case (r_phase)
        PH_SETUP: begin
          w_phase_next = PH_EN;
          w_cnt_next   = 32'd0;
        end
        PH_EN: begin
          if (r_cnt == 32'(EN_CYC - 1)) begin
            w_phase_next = PH_HOLD;
            w_cnt_next   = 32'd0;
          end
        end
        PH_HOLD: begin
          if (r_cnt == w_hold_last) w_tx_done = 1'b1;
        end
        default: w_phase_next = PH_SETUP;
      endcase
    end

    case (r_state)
      S_PWR: begin
        if (r_cnt == 32'(PWR_CYC - 1)) begin
          w_state_next    = S_INIT;
          w_init_idx_next = 2'd0;
          w_load          = 1'b1;
          w_load_data     = f_init_cmd(2'd0);
        end
      end
      S_INIT: begin
        if (w_tx_done) begin
          if (r_init_idx == 2'd3) begin
            w_state_next    = S_ROW;
            w_row_next      = 2'd0;
            w_init_done_set = 1'b1;
            w_load          = 1'b1;
            w_load_data     = f_row_cmd(2'd0);
          end else begin
            w_init_idx_next = r_init_idx + 2'd1;
            w_load          = 1'b1;
            w_load_data     = f_init_cmd(r_init_idx + 2'd1);
          end
        end
      end
      S_ROW: begin
        if (w_tx_done) begin
          w_state_next = S_CHAR;
          w_col_next   = 6'd0;
          w_load_char  = 1'b1;
        end
      end
      S_CHAR: begin
        if (w_tx_done) begin
          if (r_col == 6'(COLS - 1)) begin
            if (r_row == 2'(ROWS - 1)) begin
              w_state_next = S_END;
            end else begin
              w_state_next = S_ROW;
              w_row_next   = r_row + 2'd1;
              w_load       = 1'b1;
              w_load_data  = f_row_cmd(r_row + 2'd1);
            end
          end else begin
            w_col_next  = r_col + 6'd1;
            w_load_char = 1'b1;
          end
        end
      end
      S_END: begin
        w_end = 1'b1;
        if (AUTO_REFRESH != 0) begin
          w_state_next = S_ROW;
          w_row_next   = 2'd0;
          w_load       = 1'b1;
          w_load_data  = f_row_cmd(2'd0);
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_IDLE: begin
        w_cnt_next = 32'd0;
        if (r_dirty || r_pend) begin
          w_leave_idle = 1'b1;
          w_state_next = S_ROW;
          w_row_next   = 2'd0;
          w_load       = 1'b1;
          w_load_data  = f_row_cmd(2'd0);
        end
      end
      default: w_state_next = S_PWR;
    endcase

    if (w_load_char) begin
      w_load      = 1'b1;
      w_load_rs   = 1'b1;
      w_load_data = r_buf[f_idx(w_row_next, w_col_next)];
    end
    if (w_load) begin
      w_phase_next = PH_SETUP;
      w_cnt_next   = 32'd0;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_PWR;
      r_phase    <= PH_SETUP;
      r_cnt      <= 32'd0;
      r_init_idx <= 2'd0;
      r_row      <= 2'd0;
      r_col      <= 6'd0;
    end else begin
      r_state    <= w_state_next;
      r_phase    <= w_phase_next;
      r_cnt      <= w_cnt_next;
      r_init_idx <= w_init_idx_next;
      r_row      <= w_row_next;
      r_col      <= w_col_next;
    end
  end

  // Bus byte and RS are captured at the start of SETUP and held to the end of HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs   <= 1'b0;
      r_data <= 8'h00;
    end else if (w_load) begin
      r_rs   <= w_load_rs;
      r_data <= w_load_data;
    end
  end

  // init_done is sticky until reset; init is never repeated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_init_done <= 1'b0;
    else if (w_init_done_set) r_init_done <= 1'b1;
  end

  // Frame bookkeeping: dirty, late-write and pending-refresh flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dirty <= 1'b0;
      r_stale <= 1'b0;
      r_pend  <= 1'b0;
      r_sent  <= '0;
    end else begin
      if (w_wr_ok) r_dirty <= 1'b1;
      else if (w_end && !r_stale) r_dirty <= 1'b0;

      if (w_end) r_stale <= 1'b0;
      else if (w_stale_wr) r_stale <= 1'b1;

      if (refresh_req) r_pend <= 1'b1;
      else if (w_leave_idle) r_pend <= 1'b0;

      if (w_end) r_sent <= '0;
      else if (w_load_char) r_sent <= r_sent + (AW + 1)'(1);
    end
  end

  // Display buffer; reset fills every cell with a space.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CELLS; i++) r_buf[i] <= 8'h20;
    end else if (w_wr_ok) begin
      r_buf[wr_addr] <= wr_data;
    end
  end

  assign lcd_rs     = r_rs;
  assign lcd_rw     = 1'b0;
  assign lcd_en     = w_in_tx && (r_phase == PH_EN);
  assign lcd_data   = r_data;
  assign init_done  = r_init_done;
  assign frame_done = (r_state == S_END);

endmodule

// File: tb/tb_lcd_char_ctrl.sv
// Bench for lcd_char_ctrl: an on-demand 2x16 instance (A) and a
// free-running 4x20 instance (B). Bus bytes are captured on each lcd_en
// fall and compared with frames built from a model copy of the buffer.
module tb_lcd_char_ctrl;
  localparam int CA = 16, RA = 2, CB = 20, RB = 4;
  localparam int T_PWR = 100, T_CMD = 5, T_CLR = 20, EN_C = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_wr_en = 0, a_ref = 0;
  logic [4:0] a_wr_addr = 0;
  logic [7:0] a_wr_data = 0;
  logic       a_rs, a_rw, a_en, a_idone, a_fd;
  logic [7:0] a_data;
  logic       b_wr_en = 0, b_ref = 0;
  logic [6:0] b_wr_addr = 0;
  logic [7:0] b_wr_data = 0;
  logic       b_rs, b_rw, b_en, b_idone, b_fd;
  logic [7:0] b_data;

  lcd_char_ctrl #(.CLK_HZ(1_000_000), .COLS(CA), .ROWS(RA), .AUTO_REFRESH(0),
    .T_PWR_US(T_PWR), .T_CMD_US(T_CMD), .T_CLR_US(T_CLR), .T_EN_NS(1000)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .refresh_req(a_ref), .lcd_rs(a_rs), .lcd_rw(a_rw), .lcd_en(a_en), .lcd_data(a_data),
    .init_done(a_idone), .frame_done(a_fd));

  lcd_char_ctrl #(.CLK_HZ(1_000_000), .COLS(CB), .ROWS(RB), .AUTO_REFRESH(1),
    .T_PWR_US(T_PWR), .T_CMD_US(T_CMD), .T_CLR_US(T_CLR), .T_EN_NS(1000)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .refresh_req(b_ref), .lcd_rs(b_rs), .lcd_rw(b_rw), .lcd_en(b_en), .lcd_data(b_data),
    .init_done(b_idone), .frame_done(b_fd));

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         cyc;
    logic       idn;
  } item_t;

  item_t      qa[$], qb[$];
  int         cyc = 0, fda = 0, fdb = 0;
  logic       a_en_d = 0, b_en_d = 0;
  int         total = 0, bad = 0;
  logic [7:0] ma[32], mb[80], snap[80];

  always @(posedge clk) cyc <= cyc + 1;

  // Capture each transaction when lcd_en is seen to have fallen.
  always @(negedge clk) begin
    if (a_en_d && !a_en) qa.push_back('{rs: a_rs, d: a_data, cyc: cyc, idn: a_idone});
    if (b_en_d && !b_en) qb.push_back('{rs: b_rs, d: b_data, cyc: cyc, idn: b_idone});
    a_en_d <= a_en;
    b_en_d <= b_en;
    if (a_fd) fda <= fda + 1;
    if (b_fd) fdb <= fdb + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    total++;
    assert (obs >= lo && obs <= hi) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  function automatic int qsize(input int w);
    return (w == 0) ? qa.size() : qb.size();
  endfunction

  function automatic item_t pop_item(input int w);
    item_t it;
    it = '{rs: 1'bx, d: 8'hxx, cyc: -1, idn: 1'bx};
    if (w == 0 && qa.size() > 0) it = qa.pop_front();
    if (w == 1 && qb.size() > 0) it = qb.pop_front();
    return it;
  endfunction

  task automatic wait_q(input int w, input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (qsize(w) < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(qsize(w) >= n), 32'd1);
  endtask

  // Power-on wait, the four init commands, their spacing and init_done timing.
  task automatic check_init(input int w, input int rel, input string tag);
    item_t it;
    int    prev_cyc;
    logic [7:0] cmds[4];
    logic [7:0] prev_d;
    cmds = '{8'h38, 8'h0C, 8'h01, 8'h06};
    prev_cyc = 0;
    prev_d = 8'h00;
    for (int i = 0; i < 4; i++) begin
      it = pop_item(w);
      chk($sformatf("%s_cmd%0d", tag, i), {23'd0, it.rs, it.d}, {23'd0, 1'b0, cmds[i]});
      if (i == 0) chk_rng($sformatf("%s_pwr_wait", tag), it.cyc - rel, T_PWR + 2, T_PWR + 4);
      else chk($sformatf("%s_gap%0d", tag, i), 32'(it.cyc - prev_cyc),
               32'(1 + EN_C + ((prev_d == 8'h01) ? T_CLR : T_CMD)));
      if (i == 3) chk($sformatf("%s_idone_early", tag), 32'(it.idn), 32'd0);
      prev_cyc = it.cyc;
      prev_d = cmds[i];
    end
  endtask

  // One frame: per row a DDRAM address command then the row's characters.
  task automatic check_frame(input int w, input int rows, input int cols, input string tag);
    item_t it;
    int    base;
    for (int r = 0; r < rows; r++) begin
      base = ((r % 2) ? 'h40 : 0) + ((r >= 2) ? cols : 0);
      it = pop_item(w);
      chk($sformatf("%s_row%0d", tag, r), {23'd0, it.rs, it.d}, 32'('h80 + base));
      if (r == 0) chk($sformatf("%s_idone", tag), 32'(it.idn), 32'd1);
      for (int c = 0; c < cols; c++) begin
        it = pop_item(w);
        chk($sformatf("%s_r%0dc%0d", tag, r, c), {23'd0, it.rs, it.d},
            {23'd0, 1'b1, snap[r * cols + c]});
      end
    end
  endtask

  task automatic snap_a();
    for (int i = 0; i < 32; i++) snap[i] = ma[i];
  endtask

  task automatic write_a(input int addr, input logic [7:0] d);
    @(negedge clk);
    a_wr_en = 1; a_wr_addr = 5'(addr); a_wr_data = d;
    ma[addr] = d;
  endtask

  task automatic pulse_ref_a();
    @(negedge clk); a_ref = 1;
    @(negedge clk); a_ref = 0;
  endtask

  task automatic idle_check_a(input int frames, input string tag);
    int n;
    n = qa.size();
    repeat (300) @(negedge clk);
    chk({tag, "_bus_idle"}, 32'(qa.size()), 32'(n));
    chk({tag, "_frames"}, 32'(fda), 32'(frames));
  endtask

  initial begin
    int rel, addr, k;
    logic [7:0] d, v0, v20;
    for (int i = 0; i < 32; i++) ma[i] = 8'h20;
    for (int i = 0; i < 80; i++) mb[i] = 8'h20;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rs", 32'(a_rs), 0);
    chk("rst_rw", 32'(a_rw), 0);
    chk("rst_en", 32'(a_en), 0);
    chk("rst_data", 32'(a_data), 0);
    chk("rst_idone", 32'(a_idone), 0);
    chk("rst_fd", 32'(a_fd), 0);
    chk("rst_b_en_data", {23'd0, b_en, b_data}, 0);

    @(negedge clk); rst_n = 1; rel = cyc;

    // B: random writes during power-on; every third one out of range.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      addr = (i % 3 == 0) ? int'($urandom_range(80, 127)) : int'($urandom_range(0, 79));
      d = 8'($urandom_range(33, 126));
      b_wr_en = 1; b_wr_addr = 7'(addr); b_wr_data = d;
      if (addr < 80) mb[addr] = d;
    end
    @(negedge clk); b_wr_en = 0;

    // A: init sequence then one frame of spaces, then silence.
    wait_q(0, 4, 400, "a_init_wait");
    check_init(0, rel, "a_init");
    wait_q(0, 2 * (CA + 1), 1000, "a_frame1_wait");
    snap_a();
    check_frame(0, RA, CA, "a_f1");
    idle_check_a(1, "a_f1");

    // B: 4-row addressing with the randomly written buffer, then auto rescan.
    wait_q(1, 4 + RB * (CB + 1) + 1, 2000, "b_frame_wait");
    check_init(1, rel, "b_init");
    for (int i = 0; i < 80; i++) snap[i] = mb[i];
    check_frame(1, RB, CB, "b_f1");
    chk("b_auto_rescan", {23'd0, qb[0].rs, qb[0].d}, 32'h80);

    // A: refresh_req alone gives exactly one frame.
    pulse_ref_a();
    wait_q(0, 2 * (CA + 1), 1000, "a_ref_wait");
    snap_a();
    check_frame(0, RA, CA, "a_ref");
    idle_check_a(2, "a_ref");

    // A: a burst of writes in idle (including 'A' at 17) gives one frame.
    write_a(17, 8'h41);
    for (int i = 0; i < 3; i++) write_a(int'($urandom_range(0, 31)), 8'($urandom_range(33, 126)));
    @(negedge clk); a_wr_en = 0;
    wait_q(0, 2 * (CA + 1), 1000, "a_wr_wait");
    snap_a();
    check_frame(0, RA, CA, "a_wr");
    idle_check_a(3, "a_wr");

    // A: mid-frame writes. Cell 0 is already sent (shows next frame and forces
    // a second frame); cell 20 is not yet sent and shows in this frame.
    snap_a();
    pulse_ref_a();
    wait_q(0, 6, 300, "a_mid_wait");
    v0 = 8'($urandom_range(33, 126));
    v20 = 8'($urandom_range(33, 126));
    write_a(0, v0);
    write_a(20, v20);
    @(negedge clk); a_wr_en = 0;
    snap[20] = v20;
    wait_q(0, 2 * (CA + 1), 1000, "a_mid1_wait");
    check_frame(0, RA, CA, "a_mid1");
    wait_q(0, 2 * (CA + 1), 1000, "a_mid2_wait");
    snap_a();
    check_frame(0, RA, CA, "a_mid2");
    idle_check_a(5, "a_mid");

    // A: reset while lcd_en is high.
    pulse_ref_a();
    k = 0;
    while (a_en !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("a_en_seen", 32'(a_en), 1);
    #2 rst_n = 0;
    #1 chk("a_rst_en_drop", 32'(a_en), 0);
    chk("a_rst_idone", 32'(a_idone), 0);
    @(negedge clk);
    chk("a_rst_data", 32'(a_data), 0);
    repeat (2) @(negedge clk);
    rst_n = 1; rel = cyc;
    qa.delete();
    for (int i = 0; i < 32; i++) ma[i] = 8'h20;
    wait_q(0, 4, 400, "a_reinit_wait");
    check_init(0, rel, "a_reinit");
    wait_q(0, 2 * (CA + 1), 1000, "a_reframe_wait");
    snap_a();
    check_frame(0, RA, CA, "a_reframe");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
